// File: rtl/down_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Flags terminal count with a one-cycle tc pulse and a sticky done flag.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] reload_q, reload_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] eff_count;
  logic             tc_next, done_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      reload_q <= '0;
      tc       <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      reload_q <= reload_next;
      tc       <= tc_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = load ? load_val : reload_q;
    tc_next     = 1'b0;
    done_next   = done;
    // A load in the same cycle as start supplies the starting value.
    eff_count   = load ? load_val : count;

    case (state)
      IDLE, EXPIRED: begin
        if (load)
          count_next = load_val;
        if (start && (eff_count != '0)) begin
          state_next = RUN;
          done_next  = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (count == ONE) begin
          tc_next = 1'b1;
          // Reload uses the pre-edge reload_q, so a coincident load waits a period.
          if (auto_reload && (reload_q != '0)) begin
            count_next = reload_q;
          end else begin
            count_next = '0;
            state_next = EXPIRED;
            done_next  = 1'b1;
          end
        end else begin
          count_next = count - ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: 4-bit and 8-bit instances share clk/reset.
// Stimulus pushes expected outputs; a monitor pops and compares after each edge.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       n_load = 0, n_start = 0, n_stop = 0, n_ar = 0;
  logic [3:0] n_load_val = '0;
  logic [3:0] n_count;
  logic       n_busy, n_tc, n_done;

  logic       w_load = 0, w_start = 0, w_stop = 0, w_ar = 0;
  logic [7:0] w_load_val = '0;
  logic [7:0] w_count;
  logic       w_busy, w_tc, w_done;

  typedef struct packed {
    logic       w;
    logic [7:0] cnt;
    logic       busy;
    logic       tc;
    logic       done;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  event  snap_ev;
  int    n_total = 0;
  int    n_pass  = 0;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(4)) dut_n (
    .clk(clk), .reset(reset), .load(n_load), .load_val(n_load_val),
    .start(n_start), .stop(n_stop), .auto_reload(n_ar),
    .count(n_count), .busy(n_busy), .tc(n_tc), .done(n_done)
  );

  down_timer #(.WIDTH(8)) dut_w (
    .clk(clk), .reset(reset), .load(w_load), .load_val(w_load_val),
    .start(w_start), .stop(w_stop), .auto_reload(w_ar),
    .count(w_count), .busy(w_busy), .tc(w_tc), .done(w_done)
  );

  task automatic push_exp(input string nm, input bit w, input logic [7:0] ec,
                          input bit eb, input bit et, input bit ed);
    exp_t e;
    e.w = w; e.cnt = ec; e.busy = eb; e.tc = et; e.done = ed;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic clear_inputs();
    n_load = 0; n_start = 0; n_stop = 0; n_ar = 0; n_load_val = '0;
    w_load = 0; w_start = 0; w_stop = 0; w_ar = 0; w_load_val = '0;
  endtask

  // One cycle: drive inputs at negedge, expect outputs after the next posedge.
  task automatic step(input string nm, input bit w, input bit ld, input logic [7:0] lv,
                      input bit st, input bit sp, input bit ar,
                      input logic [7:0] ec, input bit eb, input bit et, input bit ed);
    @(negedge clk);
    clear_inputs();
    if (w) begin
      w_load = ld; w_load_val = lv; w_start = st; w_stop = sp; w_ar = ar;
    end else begin
      n_load = ld; n_load_val = lv[3:0]; n_start = st; n_stop = sp; n_ar = ar;
    end
    push_exp(nm, w, ec, eb, et, ed);
  endtask

  initial begin
    exp_t        e;
    string       nm;
    logic [10:0] got;
    forever begin
      @(posedge clk or snap_ev);
      #1;
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        got = e.w ? {w_count, w_busy, w_tc, w_done}
                  : {4'b0000, n_count, n_busy, n_tc, n_done};
        n_total++;
        if (got !== {e.cnt, e.busy, e.tc, e.done})
          $display("FAIL %s w=%0d: got count=%0d busy=%0b tc=%0b done=%0b, expected count=%0d busy=%0b tc=%0b done=%0b",
                   nm, e.w, got[10:3], got[2], got[1], got[0], e.cnt, e.busy, e.tc, e.done);
        else begin
          n_pass++;
          $display("ok   %s w=%0d count=%0d busy=%0b tc=%0b done=%0b",
                   nm, e.w, e.cnt, e.busy, e.tc, e.done);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, checked with no clock edge involved.
    #3;
    push_exp("reset_n", 0, 8'd0, 0, 0, 0);
    push_exp("reset_w", 1, 8'd0, 0, 0, 0);
    ->snap_ev;
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-run after two decrements.
    step("rm_start", 0, 1, 8'd5, 1, 0, 0, 8'd5, 1, 0, 0);
    step("rm_dec1",  0, 0, 8'd0, 0, 0, 0, 8'd4, 1, 0, 0);
    step("rm_dec2",  0, 0, 8'd0, 0, 0, 0, 8'd3, 1, 0, 0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    push_exp("rm_async", 0, 8'd0, 0, 0, 0);
    #1;
    ->snap_ev;
    @(negedge clk);
    reset = 1'b1;

    // One-shot from 3.
    step("os_start", 0, 1, 8'd3, 1, 0, 0, 8'd3, 1, 0, 0);
    step("os_dec",   0, 0, 8'd0, 0, 0, 0, 8'd2, 1, 0, 0);
    step("os_dec",   0, 0, 8'd0, 0, 0, 0, 8'd1, 1, 0, 0);
    step("os_tc",    0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 1);
    step("os_hold",  0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 1);
    step("os_start0",0, 0, 8'd0, 1, 0, 0, 8'd0, 0, 0, 1);
    step("os_hold2", 0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 1);

    // Auto-reload with period 4, then reload-value changes.
    step("ar_start", 0, 1, 8'd4, 1, 0, 1, 8'd4, 1, 0, 0);
    for (int p = 0; p < 3; p++) begin
      step("ar_cnt", 0, 0, 8'd0, 0, 0, 1, 8'd3, 1, 0, 0);
      step("ar_cnt", 0, 0, 8'd0, 0, 0, 1, 8'd2, 1, 0, 0);
      step("ar_cnt", 0, 0, 8'd0, 0, 0, 1, 8'd1, 1, 0, 0);
      step("ar_tc",  0, 0, 8'd0, 0, 0, 1, 8'd4, 1, 1, 0);
    end
    step("ar_ld_mid",   0, 1, 8'd2, 0, 0, 1, 8'd3, 1, 0, 0);
    step("ar_cnt",      0, 0, 8'd0, 0, 0, 1, 8'd2, 1, 0, 0);
    step("ar_cnt",      0, 0, 8'd0, 0, 0, 1, 8'd1, 1, 0, 0);
    step("ar_tc2",      0, 0, 8'd0, 0, 0, 1, 8'd2, 1, 1, 0);
    step("ar_cnt",      0, 0, 8'd0, 0, 0, 1, 8'd1, 1, 0, 0);
    step("ar_ld_at_one",0, 1, 8'd3, 0, 0, 1, 8'd2, 1, 1, 0);
    step("ar_cnt",      0, 0, 8'd0, 0, 0, 1, 8'd1, 1, 0, 0);
    step("ar_tc3",      0, 0, 8'd0, 0, 0, 1, 8'd3, 1, 1, 0);
    step("ar_stop",     0, 0, 8'd0, 0, 1, 1, 8'd3, 0, 0, 0);

    // Stop on the count==1 cycle, then resume.
    step("sp_start",   0, 1, 8'd2, 1, 0, 0, 8'd2, 1, 0, 0);
    step("sp_dec",     0, 0, 8'd0, 0, 0, 0, 8'd1, 1, 0, 0);
    step("sp_stop",    0, 0, 8'd0, 0, 1, 0, 8'd1, 0, 0, 0);
    step("sp_hold",    0, 0, 8'd0, 0, 0, 0, 8'd1, 0, 0, 0);
    step("sp_restart", 0, 0, 8'd0, 1, 0, 0, 8'd1, 1, 0, 0);
    step("sp_tc",      0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 1);
    step("sp_after",   0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 1);

    // Load and start together at count 0.
    step("ls_start", 0, 1, 8'd15, 1, 0, 0, 8'd15, 1, 0, 0);
    for (int i = 14; i >= 1; i--)
      step("ls_dec", 0, 0, 8'd0, 0, 0, 0, 8'(i), 1, 0, 0);
    step("ls_tc",       0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 1);
    step("ls_zero",     0, 1, 8'd0, 1, 0, 0, 8'd0, 0, 0, 1);
    step("ls_load_idle",0, 1, 8'd7, 0, 0, 0, 8'd7, 0, 0, 1);
    step("ls_hold",     0, 0, 8'd0, 0, 0, 0, 8'd7, 0, 0, 1);

    // Wide one-shot from 255.
    step("w_start", 1, 1, 8'd255, 1, 0, 0, 8'd255, 1, 0, 0);
    for (int i = 254; i >= 1; i--)
      step("w_dec", 1, 0, 8'd0, 0, 0, 0, 8'(i), 1, 0, 0);
    step("w_tc",   1, 0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 1);
    step("w_hold", 1, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 1);

    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/down_timer.md
# down_timer

Loadable synchronous down-counter/timer. The companion block to the up/down ripple counter in the counter library: it is loaded with a start value, decrements once per `clk` to zero, and flags terminal count. It supports one-shot and auto-reload (periodic) modes, so it can serve as a programmable delay or rate generator next to the ripple counter.

## Interface
- `WIDTH`, default 4: counter and load-value width in bits.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `load`  input  1: capture `load_val` into the reload register; also loads `count` when not running.
- `load_val`  input  WIDTH: value to load.
- `start`  input  1: begin counting from the current `count`.
- `stop`  input  1: abort counting and hold `count`.
- `auto_reload`  input  1: 1 = periodic mode, 0 = one-shot. Sampled at terminal count.
- `count`  output  WIDTH: current counter value, registered.
- `busy`  output  1: high while in RUN; decoded from state.
- `tc`  output  1: terminal-count pulse, registered, one cycle wide.
- `done`  output  1: sticky one-shot-expired flag, registered.

## Operation
- States:
  - IDLE: reset state; not counting.
  - RUN: decrementing.
  - EXPIRED: one-shot finished.
- Internal register `reload_q` (WIDTH bits). It takes `load_val` on any cycle with `load`=1, in every state.
- Reset values (asserted asynchronously): state IDLE, `count`=0, `reload_q`=0, `tc`=0, `done`=0, `busy`=0.

IDLE or EXPIRED:
- `load`=1 → `count`<=`load_val`.
- `start`=1 → go to RUN if the effective count is nonzero. The effective count is `load_val` when `load` is high in the same cycle, otherwise `count`. Going to RUN clears `done`.
- `start` with effective count 0 is ignored: state, `done` and `tc` are unchanged.
- `stop` has no effect.

RUN, priority highest first:
1. `stop`=1 → go to IDLE; `count` holds; no `tc`.
2. `count`==1 with `auto_reload`=1 and `reload_q`≠0 → `count`<=`reload_q`; stay in RUN; `tc`<=1.
3. `count`==1 otherwise → `count`<=0; go to EXPIRED; `tc`<=1; `done`<=1.
4. Else → `count`<=`count`−1.

Also in RUN:
- `load` updates only `reload_q`; the running `count` is not disturbed.
- `start` is ignored.
- `tc` is 0 on every cycle not covered by rules 2 and 3.
- Arithmetic is unsigned modulo 2^WIDTH. `count` never wraps below 0, because RUN is only entered with a nonzero count.
- Auto-reload uses the `reload_q` value present in the cycle that `count`==1. A `load` in that same cycle does not affect that reload; it takes effect at the next reload.

## Timing
- Start latency: `start` sampled at edge N → `busy`=1 after edge N, and the first decrement happens at edge N+1.
- One-shot with load value L: `tc` and `done` rise after edge N+L, when `count` reaches 0. `busy` falls at the same edge.
- Auto-reload with reload value R: `tc` pulses every R cycles. `count` sequence after reload is R, R−1, …, 1, R. Value 0 never appears on `count` while running.
- `stop` takes effect at the sampling edge: `busy` falls and `count` freezes at its pre-edge value.
- `reset` low mid-count forces all reset values immediately, without waiting for `clk`.
- `reset` release is expected synchronous to `clk` (handled externally). The first edge after release may already act on `load` or `start`.

## Test plan
- Reset mid-run:
  - Stimulus: WIDTH=4, load 5, start, then pull `reset` low between edges after 2 decrements.
  - Required: `count`=0, `busy`=0, `done`=0, `tc`=0 immediately, without a clock edge.
- One-shot:
  - Stimulus: load 3, start.
  - Required: `count` goes 3, 2, 1, 0; `tc`=1 for exactly the one cycle where `count`=0; `done` stays 1; state is EXPIRED.
  - Follow-up: `start` with `count`=0 → no change.
- Auto-reload:
  - Stimulus: load 4, `auto_reload`=1, start, run 12 cycles.
  - Required: `count` goes 4, 3, 2, 1, 4, 3, 2, 1, …; `tc` pulses every 4 cycles; `done` stays 0.
  - Follow-up: load 2 mid-period → the next period is 2 cycles, and the current period is unchanged.
- Stop priority:
  - Stimulus: load 2, start, assert `stop` on the cycle `count`=1.
  - Required: IDLE, `count` holds 1, no `tc`, `done`=0.
  - Follow-up: `start` again → `count` becomes 0 one cycle later, with `tc` and `done` set.
- Load/start same cycle:
  - Stimulus: in IDLE with `count`=0, assert `load`=1 with `load_val`=15 and `start`=1 together.
  - Required: RUN entered; `count` goes 15, 14, …; `tc` fires after 15 cycles.
  - Follow-up: the same stimulus with `load_val`=0 → stays in IDLE.
- Wide instance:
  - Stimulus: WIDTH=8, load 255, one-shot.
  - Required: `tc` exactly 255 cycles after the start edge; `count` never wraps.
